tone_generator: RTL and testbench

TONE_GENERATOR -- requirements
Module: tone_generator

---
 rtl/tone_pkg.sv | 27 ++
 rtl/tone_generator_ms_tick_gen.sv | 50 +++++
 rtl/tone_generator.sv | 182 ++++++++++++++++++
 tb/tb_tone_generator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// ============================================================================
// Module      : tone_pkg
// Description : Shared state encoding and clock constants for tone_generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  // Clocks slower than 1 kHz still get a usable 1-cycle millisecond tick.
  function automatic int unsigned ms_div_f(input int unsigned clk_hz);
    return (clk_hz >= 32'd1000) ? (clk_hz / 32'd1000) : 32'd1;
  endfunction

  localparam int unsigned MS_DIV = ms_div_f(CLK_HZ_DEFAULT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_REST = 2'd2
  } tone_state_t;

endpackage

`default_nettype wire

// File: rtl/tone_generator_ms_tick_gen.sv
// ============================================================================
// Module      : ms_tick_gen
// Description : Millisecond prescaler, one-cycle tick every DIV enabled cycles,
//               with synchronous clear. Built only with TONE_GEN_DURATION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TONE_GEN_DURATION_EN
module ms_tick_gen
  import tone_pkg::*;
#(
  parameter int unsigned DIV = MS_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : (cnt_q + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/tone_generator.sv
// ============================================================================
// Module      : tone_generator
// Description : Square-wave speaker driver with glitch-free retune; optional
//               note-duration timer compiled in by TONE_GEN_DURATION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_generator
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] maxcount,
  input  logic        load,
  input  logic [15:0] duration_ms,
  output logic        speaker,
  output logic        busy,
  output logic        done
);

`ifdef TONE_GEN_DURATION_EN
  localparam tone_state_t SILENT_STATE = S_REST;
`else
  localparam tone_state_t SILENT_STATE = S_IDLE;
`endif

  tone_state_t state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] cur_max_q, cur_max_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        spk_q, spk_d;
  logic        done_q, done_d;

  logic        boundary;
  logic [15:0] next_max;
  logic        expire;

  assign boundary = (state_q == S_TONE) && (hcnt_q == (cur_max_q - 16'd1));
  assign next_max = load ? maxcount : pend_q;

`ifdef TONE_GEN_DURATION_EN
  localparam int unsigned TICK_DIV = ms_div_f(CLK_HZ);

  logic [15:0] dur_q, dur_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic        ms_tick;
  logic        ms_en;

  assign ms_en  = (state_q != S_IDLE) && (dur_q != 16'd0);
  assign expire = ms_tick && ((ms_cnt_q + 16'd1) == dur_q);

  ms_tick_gen #(
    .DIV (TICK_DIV)
  ) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load),
    .en_i   (ms_en),
    .tick_o (ms_tick)
  );

  always_comb begin
    dur_d    = load ? duration_ms : dur_q;
    ms_cnt_d = ms_cnt_q;
    if (load || expire) begin
      ms_cnt_d = 16'd0;
    end else if (ms_tick) begin
      ms_cnt_d = ms_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q    <= 16'd0;
      ms_cnt_q <= 16'd0;
    end else begin
      dur_q    <= dur_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end
`else
  logic unused_dur;
  assign unused_dur = ^duration_ms;
  assign expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hcnt_q     <= 16'd0;
      cur_max_q  <= 16'd0;
      pend_q     <= 16'd0;
      pend_vld_q <= 1'b0;
      spk_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      cur_max_q  <= cur_max_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      spk_q      <= spk_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    cur_max_d  = cur_max_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    spk_d      = spk_q;
    done_d     = 1'b0;

    // A load that lands on duration expiry starts a fresh note instead.
    if (load && ((state_q != S_TONE) || expire)) begin
      hcnt_d     = 16'd0;
      spk_d      = 1'b0;
      pend_vld_d = 1'b0;
      if (maxcount != 16'd0) begin
        state_d   = S_TONE;
        cur_max_d = maxcount;
      end else begin
        state_d   = SILENT_STATE;
      end
    end else if (expire) begin
      done_d     = 1'b1;
      state_d    = S_IDLE;
      spk_d      = 1'b0;
      hcnt_d     = 16'd0;
      pend_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_TONE: begin
          if (load) begin
            pend_d     = maxcount;
            pend_vld_d = 1'b1;
          end
          if (boundary) begin
            hcnt_d = 16'd0;
            if (load || pend_vld_q) begin
              pend_vld_d = 1'b0;
              cur_max_d  = next_max;
              if (next_max == 16'd0) begin
                spk_d   = 1'b0;
                state_d = SILENT_STATE;
              end else begin
                spk_d   = ~spk_q;
              end
            end else begin
              spk_d = ~spk_q;
            end
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end
        S_IDLE, S_REST: begin
          spk_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          spk_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign speaker = spk_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_generator.sv
// ============================================================================
// Module      : tb_tone_generator
// Description : Self-checking bench for tone_generator: time-based note model,
//               per-cycle compare, literal pins and randomized loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_generator;

  localparam int unsigned MSD = 100;
`ifdef TONE_GEN_DURATION_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] maxcount = 16'd0;
  logic [15:0] duration_ms = 16'd0;
  logic        speaker;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 1'b0;
  int unsigned cyc = 0;

  // Model: notes described by the cycle of their next toggle and expiry.
  int          m_state = 0;
  bit          m_spk = 1'b0;
  bit          m_done = 1'b0;
  bit          m_pend_v = 1'b0;
  int unsigned m_half = 0;
  int unsigned m_next = 0;
  int unsigned m_pend = 0;
  int unsigned m_exp_at = 0;

  tone_generator #(
    .CLK_HZ (100_000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .maxcount    (maxcount),
    .load        (load),
    .duration_ms (duration_ms),
    .speaker     (speaker),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit exp_now;
    cyc++;
    m_done  = 1'b0;
    exp_now = DUR && (m_state != 0) && (m_exp_at == cyc);
    if (load && ((m_state != 1) || exp_now)) begin
      if (DUR) m_exp_at = (duration_ms != 16'd0) ? cyc + 32'(duration_ms) * MSD : 0;
      m_pend_v = 1'b0;
      m_spk    = 1'b0;
      if (maxcount != 16'd0) begin
        m_state = 1;
        m_half  = 32'(maxcount);
        m_next  = cyc + 32'(maxcount);
      end else if (DUR) begin
        m_state = 2;
      end
    end else if (exp_now) begin
      m_done   = 1'b1;
      m_state  = 0;
      m_spk    = 1'b0;
      m_pend_v = 1'b0;
    end else if (m_state == 1) begin
      if (load) begin
        m_pend   = 32'(maxcount);
        m_pend_v = 1'b1;
        if (DUR) m_exp_at = (duration_ms != 16'd0) ? cyc + 32'(duration_ms) * MSD : 0;
      end
      if (cyc == m_next) begin
        if (m_pend_v) begin
          m_half   = m_pend;
          m_pend_v = 1'b0;
        end
        if (m_half == 0) begin
          m_spk   = 1'b0;
          m_state = DUR ? 2 : 0;
        end else begin
          m_spk  = ~m_spk;
          m_next = cyc + m_half;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state  = 0;
        m_spk    = 1'b0;
        m_done   = 1'b0;
        m_pend_v = 1'b0;
        m_exp_at = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("speaker", speaker, m_spk);
        chk("busy", busy, m_state != 0);
        chk("done", done, m_done);
      end
    end
  end

  // Caller sits on a negedge; returns the index of the edge that samples load.
  task automatic do_load(input logic [15:0] mc, input logic [15:0] dur,
                         output int unsigned c);
    load        = 1'b1;
    maxcount    = mc;
    duration_ms = dur;
    c           = cyc + 1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int unsigned c0;
    int unsigned c1;
    logic [15:0] mc;
    logic [15:0] dr;
    int          r;

    repeat (3) @(negedge clk);
    chk("rst_speaker", speaker, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    do_load(16'd47778, 16'd0, c0);
    wait_to(c0 + 47777);
    chk("c5_before_rise", speaker, 1'b0);
    wait_to(c0 + 47778);
    chk("c5_first_rise", speaker, 1'b1);
    chk("c5_busy", busy, 1'b1);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_speaker", speaker, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk);

    rst_n = 1'b1;
    do_load(16'd478, 16'd0, c0);
    chk("load_after_rst_busy", busy, 1'b1);
    wait_to(c0 + 677);
    do_load(16'd239, 16'd0, c1);
    wait_to(c0 + 955);
    chk("retune_old_half_hi", speaker, 1'b1);
    wait_to(c0 + 956);
    chk("retune_boundary_fall", speaker, 1'b0);
    wait_to(c0 + 1194);
    chk("retune_new_half_lo", speaker, 1'b0);
    wait_to(c0 + 1195);
    chk("retune_new_rise", speaker, 1'b1);
    wait_to(c0 + 1433);
    chk("retune_new_hi", speaker, 1'b1);
    wait_to(c0 + 1434);
    chk("retune_new_fall", speaker, 1'b0);

    do_load(16'd0, 16'd0, c1);
    wait_to(c1 + 300);
    chk("silence_speaker", speaker, 1'b0);
    chk("silence_busy", busy, DUR);

    do_load(16'd1, 16'd0, c0);
    wait_to(c0 + 1);
    chk("div2_t1", speaker, 1'b1);
    wait_to(c0 + 2);
    chk("div2_t2", speaker, 1'b0);
    wait_to(c0 + 3);
    chk("div2_t3", speaker, 1'b1);
    wait_to(c0 + 4);
    chk("div2_t4", speaker, 1'b0);
    do_load(16'd0, 16'd0, c1);
    chk("div2_stop_speaker", speaker, 1'b0);
    chk("div2_stop_busy", busy, DUR);

`ifdef TONE_GEN_DURATION_EN
    do_load(16'd10, 16'd3, c0);
    wait_to(c0 + 299);
    chk("dur_pre_done", done, 1'b0);
    chk("dur_pre_busy", busy, 1'b1);
    wait_to(c0 + 300);
    chk("dur_done", done, 1'b1);
    chk("dur_speaker", speaker, 1'b0);
    chk("dur_busy", busy, 1'b0);
    wait_to(c0 + 301);
    chk("dur_done_one_cycle", done, 1'b0);

    do_load(16'd10, 16'd2, c0);
    wait_to(c0 + 199);
    do_load(16'd7, 16'd2, c1);
    chk("exp_load_no_done", done, 1'b0);
    chk("exp_load_busy", busy, 1'b1);
    chk("exp_load_speaker", speaker, 1'b0);
    wait_to(c1 + 199);
    chk("exp_load_pre_done", done, 1'b0);
    wait_to(c1 + 200);
    chk("exp_load_done", done, 1'b1);
    chk("exp_load_idle", busy, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      r = int'($urandom_range(0, 9));
      if (r == 0)      mc = 16'd0;
      else if (r == 1) mc = 16'd1;
      else if (r == 2) mc = 16'd2;
      else             mc = 16'($urandom_range(3, 60));
      dr = 16'($urandom_range(0, 4));
      do_load(mc, dr, c0);
    end
    repeat (600) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
